// File: rtl/freq_meter.sv
// freq_meter: measures period and on-time (in clk cycles) of a slow divided clock.
// Revision 1.0 - initial release
`timescale 1ns/1ps
`default_nettype none

module freq_meter #(
  parameter int POLARITE = 0,
  parameter int BUS_SIZE = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Enable,
  input  logic                SigIn,
  output logic [BUS_SIZE-1:0] Period,
  output logic [BUS_SIZE-1:0] OnTime,
  output logic                Valid,
  output logic                Stuck
);

  localparam logic                c_POL     = (POLARITE != 0);
  localparam logic [BUS_SIZE-1:0] c_TIMEOUT = BUS_SIZE'(TIMEOUT);
  localparam logic [BUS_SIZE-1:0] c_ONE     = BUS_SIZE'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_s1;
  logic                r_s2;
  logic                r_s3;
  logic [BUS_SIZE-1:0] r_per_cnt;
  logic [BUS_SIZE-1:0] r_on_cnt;
  logic [BUS_SIZE-1:0] r_period;
  logic [BUS_SIZE-1:0] r_on_time;
  logic                r_valid;
  logic                r_stuck;
  logic                w_edge;
  logic                w_on;

  // r_s1 is the metastability stage; only r_s2/r_s3 feed decisions.
  assign w_on   = (r_s2 == c_POL);
  assign w_edge = w_on && (r_s3 != c_POL);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s1      <= ~c_POL;
      r_s2      <= ~c_POL;
      r_s3      <= ~c_POL;
      r_state   <= ST_IDLE;
      r_per_cnt <= '0;
      r_on_cnt  <= '0;
      r_period  <= '0;
      r_on_time <= '0;
      r_valid   <= 1'b0;
      r_stuck   <= 1'b0;
    end else begin
      r_s1    <= SigIn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      if (!Enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // First edge only opens a window; nothing to publish yet.
            if (w_edge) begin
              r_state   <= ST_MEAS;
              r_per_cnt <= c_ONE;
              r_on_cnt  <= c_ONE;
            end
          end
          ST_MEAS: begin
            if (w_edge) begin
              r_period  <= r_per_cnt;
              r_on_time <= r_on_cnt;
              r_valid   <= 1'b1;
              r_stuck   <= 1'b0;
              r_per_cnt <= c_ONE;
              r_on_cnt  <= c_ONE;
            end else if (r_per_cnt == c_TIMEOUT) begin
              r_stuck <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_per_cnt <= r_per_cnt + c_ONE;
              if (w_on) begin
                r_on_cnt <= r_on_cnt + c_ONE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign Period = r_period;
  assign OnTime = r_on_time;
  assign Valid  = r_valid;
  assign Stuck  = r_stuck;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// tb_freq_meter: two meters (both polarities) on one stimulus, checked each cycle against a timeline model.
// Revision 1.0 - initial release
`timescale 1ns/1ps
`default_nettype none

module tb_freq_meter;

  localparam int BW = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sig;
  logic [BW-1:0] per0, on0, per1, on1;
  logic          val0, stk0, val1, stk1;

  always #5 clk = ~clk;

  freq_meter #(.POLARITE(0), .BUS_SIZE(BW), .TIMEOUT(TO)) u_p0 (
    .Clk(clk), .Rst(rst), .Enable(en), .SigIn(sig),
    .Period(per0), .OnTime(on0), .Valid(val0), .Stuck(stk0)
  );

  freq_meter #(.POLARITE(1), .BUS_SIZE(BW), .TIMEOUT(TO)) u_p1 (
    .Clk(clk), .Rst(rst), .Enable(en), .SigIn(sig),
    .Period(per1), .OnTime(on1), .Valid(val1), .Stuck(stk1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Timeline model: raw samples by cycle number, edges found two samples late.
  int  cyc        = 0;
  int  rst_cyc    = 0;
  bit  model_live = 1'b0;
  bit  rawring [0:63];
  bit  onring  [2][0:63];
  bit  armed   [2];
  int  last_edge [2];
  int  e_per [2];
  int  e_on  [2];
  bit  e_val [2];
  bit  e_stk [2];

  function automatic bit sample_ago(input int i, input int k);
    int idx;
    idx = cyc - k;
    if (idx <= rst_cyc) return (i == 1) ? 1'b0 : 1'b1;
    return rawring[idx % 64];
  endfunction

  task automatic model_step(input int i);
    bit pol;
    bit on_now;
    bit edge_now;
    int sum;
    pol      = (i == 1);
    on_now   = (sample_ago(i, 2) == pol);
    edge_now = on_now && (sample_ago(i, 3) != pol);
    onring[i][cyc % 64] = on_now;
    e_val[i] = 1'b0;
    if (!en) begin
      armed[i] = 1'b0;
    end else if (!armed[i]) begin
      if (edge_now) begin
        armed[i]     = 1'b1;
        last_edge[i] = cyc;
      end
    end else if (edge_now) begin
      sum = 0;
      for (int k = last_edge[i]; k < cyc; k++) sum += int'(onring[i][k % 64]);
      e_per[i]     = cyc - last_edge[i];
      e_on[i]      = sum;
      e_val[i]     = 1'b1;
      e_stk[i]     = 1'b0;
      last_edge[i] = cyc;
    end else if (cyc - last_edge[i] == TO) begin
      e_stk[i] = 1'b1;
      armed[i] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      rst_cyc = cyc;
      for (int i = 0; i < 2; i++) begin
        e_per[i] = 0;
        e_on[i]  = 0;
        e_val[i] = 1'b0;
        e_stk[i] = 1'b0;
        armed[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
    rawring[cyc % 64] = sig;
    cyc++;
    model_live = 1'b1;
  end

  task automatic cmp_inst(input int i, input logic [BW-1:0] p, input logic [BW-1:0] o,
                          input logic v, input logic s);
    n_cmp++;
    if (p !== BW'(e_per[i]) || o !== BW'(e_on[i]) || v !== e_val[i] || s !== e_stk[i]) begin
      n_bad++;
      $display("FAIL model_cmp inst%0d cyc=%0d got per=%0d on=%0d valid=%0b stuck=%0b exp per=%0d on=%0d valid=%0b stuck=%0b",
               i, cyc, p, o, v, s, e_per[i], e_on[i], e_val[i], e_stk[i]);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      cmp_inst(0, per0, on0, val0, stk0);
      cmp_inst(1, per1, on1, val1, stk1);
    end
  end

  task automatic lit(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step(input bit s);
    sig = s;
    @(negedge clk);
  endtask

  task automatic wave(input int lo, input int hi, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < lo; k++) step(1'b0);
      for (int k = 0; k < hi; k++) step(1'b1);
    end
  endtask

  initial begin
    int r, lo, hi, hold;
    rst = 1'b1;
    en  = 1'b0;
    sig = 1'b1;
    repeat (3) @(negedge clk);
    lit("reset_period", int'(per0), 0);
    lit("reset_valid", int'(val0), 0);
    lit("reset_stuck", int'(stk1), 0);
    rst = 1'b0;
    en  = 1'b1;

    // 2 low / 4 high on both polarities
    wave(2, 4, 5);
    lit("p0_period6", int'(per0), 6);
    lit("p0_ontime2", int'(on0), 2);
    lit("p1_period6", int'(per1), 6);
    lit("p1_ontime4", int'(on1), 4);
    lit("model_p1_on4", e_on[1], 4);
    lit("p0_nostuck", int'(stk0), 0);

    // stuck clock, then recovery
    repeat (40) step(1'b0);
    lit("p0_stuck", int'(stk0), 1);
    lit("p1_stuck", int'(stk1), 1);
    lit("p0_stuck_hold_period", int'(per0), 6);
    wave(2, 4, 4);
    lit("p0_recover_stuck", int'(stk0), 0);
    lit("p0_recover_period", int'(per0), 6);

    // period exactly TIMEOUT, then one beyond
    wave(5, 15, 3);
    lit("p0_period20", int'(per0), 20);
    lit("p0_on20", int'(on0), 5);
    lit("p1_on20", int'(on1), 15);
    lit("p1_stuck20", int'(stk1), 0);
    wave(5, 16, 3);
    lit("p0_stuck21", int'(stk0), 1);
    lit("p1_stuck21", int'(stk1), 1);
    lit("p0_hold20", int'(per0), 20);

    // reset mid-period
    wave(2, 4, 3);
    lit("p0_pre_rst", int'(per0), 6);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    lit("rst_p0_period", int'(per0), 0);
    lit("rst_p1_ontime", int'(on1), 0);
    rst = 1'b0;
    step(1'b1);
    step(1'b1);
    wave(2, 4, 3);
    lit("post_rst_p0", int'(per0), 6);
    lit("post_rst_p1_on", int'(on1), 4);

    // enable dropped mid-stream
    en = 1'b0;
    for (int k = 0; k < 10; k++) step((k % 6) >= 2);
    lit("dis_valid", int'(val0), 0);
    lit("dis_hold_period", int'(per1), 6);
    en = 1'b1;
    wave(2, 4, 3);
    lit("reen_p0_on", int'(on0), 2);
    lit("reen_p1_period", int'(per1), 6);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1;
        step(sig);
        rst = 1'b0;
      end else if (r < 8) begin
        en = ~en;
      end else if (r < 12) begin
        hold = $urandom_range(15, 30);
        for (int k = 0; k < hold; k++) step(sig);
      end
      lo = $urandom_range(1, 12);
      hi = $urandom_range(1, 12);
      wave(lo, hi, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
